// File: rtl/soma_scheduler.sv
// soma_scheduler: shares one soma among NUM_REQ requesters with config load,
// round-robin event dispatch, kill handshake and spike source tagging.
module soma_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int SPIKE_LAT = 2,
    parameter int RST_CYC   = 2,
    localparam int IW = $clog2(NUM_REQ),
    localparam int CW = $clog2(RST_CYC + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    input  logic [31:0]          cfg_word,
    output logic                 cfg_ready,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [16*NUM_REQ-1:0] req_weight,
    input  logic [16*NUM_REQ-1:0] req_interval,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 kill_req,
    output logic                 soma_rst,
    output logic                 soma_en,
    output logic                 soma_kill,
    output logic [15:0]          soma_weight,
    output logic [31:0]          soma_w_data,
    input  logic [15:0]          soma_spike,
    output logic                 spike_valid,
    output logic [15:0]          spike_data,
    output logic [IW-1:0]        spike_src,
    output logic                 busy
);
    typedef enum logic [2:0] {UNCFG, LOAD, RUN, DRAIN, KILL} state_t;
    state_t               r_state, w_next;
    logic [31:0]          r_cfg, r_wd;
    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_ptr, w_idx;
    logic                 w_any, w_grant, w_exit;
    logic [SPIKE_LAT-1:0] r_tag_v;
    logic [IW-1:0]        r_tag_id [SPIKE_LAT];

    always_comb begin
        w_any = 1'b0;
        w_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_any && req_valid[IW'((int'(r_ptr) + k) % NUM_REQ)]) begin
                w_any = 1'b1;
                w_idx = IW'((int'(r_ptr) + k) % NUM_REQ);
            end
        end
    end

    // kill_req takes priority over any pending request in the same cycle
    assign w_grant     = (r_state == RUN) && !kill_req && w_any;
    assign req_ready   = w_grant ? NUM_REQ'(1) << w_idx : '0;
    assign w_exit      = r_tag_v[SPIKE_LAT-1] && |soma_spike;
    assign cfg_ready   = r_state == UNCFG;
    assign busy        = r_state != UNCFG;
    assign soma_rst    = r_state == LOAD;
    assign soma_kill   = r_state == KILL;
    assign soma_w_data = (r_state == LOAD) ? r_cfg : r_wd;

    always_comb begin
        w_next = r_state;
        case (r_state)
            UNCFG:   if (cfg_valid) w_next = LOAD;
            LOAD:    if (r_cnt == CW'(RST_CYC - 1)) w_next = RUN;
            RUN:     if (kill_req) w_next = DRAIN;
            DRAIN:   if (r_tag_v == '0) w_next = KILL;
            default: w_next = UNCFG;
        endcase
    end

    always_ff @(posedge clk) r_state <= rst ? UNCFG : w_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg       <= '0;
            r_wd        <= '0;
            r_cnt       <= '0;
            r_ptr       <= '0;
            r_tag_v     <= '0;
            for (int k = 0; k < SPIKE_LAT; k++) r_tag_id[k] <= '0;
            soma_en     <= 1'b0;
            soma_weight <= '0;
            spike_valid <= 1'b0;
            spike_data  <= '0;
            spike_src   <= '0;
        end else begin
            r_cnt <= (r_state == LOAD) ? r_cnt + 1'b1 : '0;
            if (r_state == UNCFG && cfg_valid) r_cfg <= cfg_word;
            else if (r_state == KILL) r_cfg <= '0;
            soma_en <= w_grant;
            if (w_grant) begin
                soma_weight <= req_weight[16*w_idx +: 16];
                r_wd        <= {r_cfg[31:16], req_interval[16*w_idx +: 16]};
                r_ptr       <= IW'((int'(w_idx) + 1) % NUM_REQ);
            end else if (r_state == LOAD) begin
                r_wd <= r_cfg;
            end
            r_tag_v[0]  <= w_grant;
            r_tag_id[0] <= w_idx;
            for (int k = 1; k < SPIKE_LAT; k++) begin
                r_tag_v[k]  <= r_tag_v[k-1];
                r_tag_id[k] <= r_tag_id[k-1];
            end
            spike_valid <= w_exit;
            if (w_exit) begin
                spike_data <= soma_spike;
                spike_src  <= r_tag_id[SPIKE_LAT-1];
            end
        end
    end
endmodule

// File: tb/tb_soma_scheduler.sv
// tb_soma_scheduler: directed scenarios plus random traffic, checked every cycle
// against an event-level reference model of the scheduler.
module tb_soma_scheduler;
    localparam int N = 4;
    localparam int L = 2;
    localparam int RC = 2;
    localparam int PU = 0, PL = 1, PR = 2, PD = 3, PK = 4;

    logic        clk = 0, rst = 1, cfg_valid = 0, kill_req = 0;
    logic [31:0] cfg_word = 0;
    logic [3:0]  req_valid = 0;
    logic [63:0] req_weight = 0, req_interval = 0;
    logic [15:0] soma_spike = 0;
    logic        cfg_ready, soma_rst, soma_en, soma_kill, spike_valid, busy;
    logic [3:0]  req_ready;
    logic [15:0] soma_weight, spike_data;
    logic [31:0] soma_w_data;
    logic [1:0]  spike_src;

    soma_scheduler #(.NUM_REQ(N), .SPIKE_LAT(L), .RST_CYC(RC)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_word(cfg_word), .cfg_ready(cfg_ready),
        .req_valid(req_valid), .req_weight(req_weight), .req_interval(req_interval),
        .req_ready(req_ready), .kill_req(kill_req), .soma_rst(soma_rst), .soma_en(soma_en),
        .soma_kill(soma_kill), .soma_weight(soma_weight), .soma_w_data(soma_w_data),
        .soma_spike(soma_spike), .spike_valid(spike_valid), .spike_data(spike_data),
        .spike_src(spike_src), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase, round-robin pointer and a queue of in-flight events
    typedef struct {int due; int src;} flight_t;
    flight_t     fq[$];
    int          phase = PU, ptr = 0, lcnt = 0, cyc = 0;
    bit          started = 0;
    logic [31:0] cfg = 0, e_wd = 0;
    logic [15:0] e_w = 0, e_sd = 0;
    logic [1:0]  e_ss = 0;
    logic        e_en = 0, e_sv = 0;

    function automatic int pick();
        if (phase != PR || kill_req) return -1;
        for (int k = 0; k < N; k++) if (req_valid[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    initial forever begin
        int g;
        bit empty;
        @(posedge clk);
        if (rst) begin
            phase = PU; ptr = 0; lcnt = 0; cfg = 0; fq.delete();
            e_en = 0; e_w = 0; e_wd = 0; e_sv = 0; e_sd = 0; e_ss = 0;
            started = 1;
        end else begin
            g = pick();
            empty = fq.size() == 0;
            e_sv = 0;
            if (!empty && fq[0].due == cyc) begin
                if (soma_spike != 0) begin
                    e_sv = 1; e_sd = soma_spike; e_ss = 2'(fq[0].src);
                end
                void'(fq.pop_front());
            end
            e_en = g >= 0;
            if (g >= 0) begin
                e_w  = req_weight[16*g +: 16];
                e_wd = {cfg[31:16], req_interval[16*g +: 16]};
                ptr  = (g + 1) % N;
                fq.push_back('{cyc + L, g});
            end
            case (phase)
                PU: if (cfg_valid) begin cfg = cfg_word; e_wd = cfg_word; lcnt = 0; phase = PL; end
                PL: begin lcnt++; if (lcnt == RC) phase = PR; end
                PR: if (kill_req) phase = PD;
                PD: if (empty) phase = PK;
                default: begin cfg = 0; phase = PU; end
            endcase
        end
        cyc++;
    end

    initial forever begin
        int g;
        @(negedge clk);
        if (started) begin
            g = pick();
            chk("cfg_ready", cfg_ready, phase == PU);
            chk("busy", busy, phase != PU);
            chk("soma_rst", soma_rst, phase == PL);
            chk("soma_kill", soma_kill, phase == PK);
            chk("req_ready", req_ready, g < 0 ? 0 : (1 << g));
            chk("soma_en", soma_en, e_en);
            chk("soma_weight", soma_weight, e_w);
            chk("soma_w_data", soma_w_data, e_wd);
            chk("spike_valid", spike_valid, e_sv);
            chk("spike_data", spike_data, e_sd);
            chk("spike_src", spike_src, e_ss);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] iv;
        logic [15:0] prev;
        bit found;
        repeat (3) tick();
        rst = 0;
        @(negedge clk);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_spike_valid", spike_valid, 0);
        // T1 config load
        tick(); cfg_valid = 1; cfg_word = 32'h40030508;
        tick(); cfg_valid = 0;
        @(negedge clk);
        chk("t1_soma_rst1", soma_rst, 1);
        chk("t1_w_data", soma_w_data, 32'h40030508);
        chk("t1_busy", busy, 1);
        tick(); @(negedge clk); chk("t1_soma_rst2", soma_rst, 1);
        tick(); @(negedge clk); chk("t1_run_rst", soma_rst, 0); chk("t1_run_cfg_ready", cfg_ready, 0);
        // T2 all requesters valid for 8 cycles
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            req_valid = 4'hF;
            req_weight = {$urandom, $urandom};
            iv = {$urandom, $urandom};
            req_interval = iv;
            @(negedge clk);
            chk("t2_grant", req_ready, 32'(1) << (i % 4));
            if (i > 0) chk("t2_w_data", soma_w_data, {16'h4003, prev});
            prev = iv[16*(i%4) +: 16];
        end
        tick(); req_valid = 0;
        @(negedge clk);
        chk("t2_last_en", soma_en, 1);
        chk("t2_last_w_data", soma_w_data, {16'h4003, prev});
        repeat (3) tick();
        // T3 single requester, known soma result
        req_valid = 4'b0100; req_weight = 64'h0000_0010_0000_0000; soma_spike = 16'h0007;
        @(negedge clk); chk("t3_grant", req_ready, 4'b0100);
        tick(); req_valid = 0;
        @(negedge clk); chk("t3_en", soma_en, 1); chk("t3_weight", soma_weight, 16'h0010);
        tick(); @(negedge clk); chk("t3_early", spike_valid, 0);
        tick(); @(negedge clk);
        chk("t3_valid", spike_valid, 1); chk("t3_data", spike_data, 7); chk("t3_src", spike_src, 2);
        // T4/T5 kill with two tags in flight and a simultaneous request
        tick(); req_valid = 4'hF; soma_spike = 16'h0003;
        tick();
        tick(); kill_req = 1;
        @(negedge clk); chk("t5_kill_ready", req_ready, 0);
        tick(); kill_req = 0;
        @(negedge clk);
        chk("t5_no_en", soma_en, 0); chk("t4_drain_ready", req_ready, 0);
        chk("t4_spike1", spike_valid, 1); chk("t4_src1", spike_src, 3);
        tick(); @(negedge clk); chk("t4_spike2", spike_valid, 1); chk("t4_src2", spike_src, 0);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(); @(negedge clk);
            found = soma_kill;
        end
        chk("t4_kill_seen", found, 1);
        tick(); req_valid = 0;
        @(negedge clk); chk("t4_kill_once", soma_kill, 0); chk("t4_cfg_ready", cfg_ready, 1);
        // T6 reset during RUN with tags in flight
        tick(); cfg_valid = 1; cfg_word = $urandom;
        tick(); cfg_valid = 0;
        repeat (2) tick();
        req_valid = 4'hF; soma_spike = 16'h0005;
        tick();
        tick(); rst = 1; req_valid = 0;
        tick(); rst = 0;
        @(negedge clk);
        chk("t6_spike_valid", spike_valid, 0); chk("t6_busy", busy, 0);
        chk("t6_en", soma_en, 0); chk("t6_w_data", soma_w_data, 0);
        repeat (3) begin tick(); @(negedge clk); chk("t6_no_spike", spike_valid, 0); end
        // Random traffic
        for (int i = 0; i < 800; i++) begin
            tick();
            rst = $urandom_range(0, 299) == 0;
            cfg_valid = $urandom_range(0, 3) == 0;
            cfg_word = $urandom;
            req_valid = 4'($urandom);
            req_weight = {$urandom, $urandom};
            req_interval = {$urandom, $urandom};
            soma_spike = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom);
            kill_req = $urandom_range(0, 29) == 0;
        end
        tick();
        rst = 0; cfg_valid = 0; req_valid = 0; kill_req = 0;
        repeat (5) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
